fmm_row_update_apply: RTL

FMM_ROW_UPDATE_APPLY -- requirements
Module: fmm_row_update_apply

---
 rtl/fmm_reduce_pkg.sv | 30 +++
 rtl/fmm_row_addr_gen.sv | 11 +
 rtl/fmm_row_update_apply.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fmm_reduce_pkg.sv
// Shared constants, state encoding and row-base helper for the FMM reduce stages.
package fmm_reduce_pkg;

  localparam int unsigned NCOLS = 320;
  localparam int unsigned NROWS = 409;
  localparam int unsigned AW    = 17;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNTW  = 16;

  localparam logic [DW-1:0] NO_MOVE = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_RD_PIV = 3'd2;
  localparam logic [2:0] ST_RD_TGT = 3'd3;
  localparam logic [2:0] ST_FLUSH  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef struct packed {
    logic [DW-1:0] pivot_row;
    logic [DW-1:0] row2;
    logic [DW-1:0] k;
  } move_req_t;

  // row * 320 as shift-add, wrapped into the M_e address space
  function automatic logic [AW-1:0] row_base(input logic [DW-1:0] row);
    return AW'((row << 8) + (row << 6));
  endfunction

endpackage

// File: rtl/fmm_row_addr_gen.sv
// Row base address generator shared with the upstream scan stage.
module fmm_row_addr_gen
  import fmm_reduce_pkg::*;
(
  input  logic [DW-1:0] i_row,
  output logic [AW-1:0] o_base_c
);

  assign o_base_c = row_base(i_row);

endmodule

// File: rtl/fmm_row_update_apply.sv
// Applies one row move M_e[row2] -= k * M_e[pivot_row], two cycles per column.
module fmm_row_update_apply #(
  parameter int unsigned NCOLS = fmm_reduce_pkg::NCOLS,
  parameter int unsigned NROWS = fmm_reduce_pkg::NROWS
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_ready,
  output logic        ap_idle,
  input  logic [31:0] pivot_row,
  input  logic [31:0] row2,
  input  logic [31:0] move_type,
  output logic [16:0] M_e_address0,
  output logic        M_e_ce0,
  input  logic [31:0] M_e_q0,
  output logic [16:0] M_e_address1,
  output logic        M_e_ce1,
  output logic        M_e_we1,
  output logic [31:0] M_e_d1,
  output logic        skipped,
  output logic        err_range,
  output logic [15:0] cols_written
);
  import fmm_reduce_pkg::*;

  localparam logic [CNTW-1:0] LAST_COL = CNTW'(NCOLS - 1);

  logic [2:0]      r_state, w_state_nxt;
  move_req_t       r_req, w_req_nxt;
  logic [CNTW-1:0] r_c, w_c_nxt;
  logic [DW-1:0]   r_piv_word, w_piv_word_nxt;
  logic            r_skipped, w_skipped_nxt;
  logic            r_err, w_err_nxt;
  logic [CNTW-1:0] r_cols, w_cols_nxt;
  logic            r_done, r_idle, r_ce0, r_ce1;
  logic            w_ce0_nxt, w_ce1_nxt;
  logic [AW-1:0]   r_addr0, w_addr0_nxt, r_addr1, w_addr1_nxt;
  logic [AW-1:0]   w_piv_base, w_tgt_base;
  logic [DW-1:0]   w_prod;

  fmm_row_addr_gen u_piv_addr (.i_row(r_req.pivot_row), .o_base_c(w_piv_base));
  fmm_row_addr_gen u_tgt_addr (.i_row(r_req.row2),      .o_base_c(w_tgt_base));

  // Next state, latched request and memory port requests for the state being entered
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_c_nxt        = r_c;
    w_piv_word_nxt = r_piv_word;
    w_skipped_nxt  = r_skipped;
    w_err_nxt      = r_err;
    w_cols_nxt     = (r_ce1 && (r_cols != '1)) ? r_cols + CNTW'(1) : r_cols;
    unique case (r_state)
      ST_IDLE: begin
        if (ap_start) begin
          w_req_nxt     = '{pivot_row: pivot_row, row2: row2, k: move_type};
          w_cols_nxt    = '0;
          w_skipped_nxt = 1'b0;
          w_err_nxt     = 1'b0;
          w_state_nxt   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if ((r_req.row2 == NO_MOVE) || (r_req.k == '0)) begin
          w_skipped_nxt = 1'b1;
          w_state_nxt   = ST_DONE;
        end else if ((r_req.row2 >= 32'(NROWS)) || (r_req.pivot_row >= 32'(NROWS))) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_c_nxt     = '0;
          w_state_nxt = ST_RD_PIV;
        end
      end
      ST_RD_PIV: w_state_nxt = ST_RD_TGT;
      ST_RD_TGT: begin
        w_piv_word_nxt = M_e_q0;
        if (r_c == LAST_COL) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_c_nxt     = r_c + CNTW'(1);
          w_state_nxt = ST_RD_PIV;
        end
      end
      ST_FLUSH: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    w_ce0_nxt   = (w_state_nxt == ST_RD_PIV) || (w_state_nxt == ST_RD_TGT);
    w_ce1_nxt   = ((w_state_nxt == ST_RD_PIV) && (w_c_nxt != '0)) || (w_state_nxt == ST_FLUSH);
    w_addr0_nxt = ((w_state_nxt == ST_RD_TGT) ? w_tgt_base : w_piv_base) + AW'(w_c_nxt);
    w_addr1_nxt = w_tgt_base + AW'(r_c);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= ST_IDLE;
      r_req      <= '0;
      r_c        <= '0;
      r_piv_word <= '0;
      r_skipped  <= 1'b0;
      r_err      <= 1'b0;
      r_cols     <= '0;
      r_done     <= 1'b0;
      r_idle     <= 1'b1;
      r_ce0      <= 1'b0;
      r_ce1      <= 1'b0;
      r_addr0    <= '0;
      r_addr1    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_c        <= w_c_nxt;
      r_piv_word <= w_piv_word_nxt;
      r_skipped  <= w_skipped_nxt;
      r_err      <= w_err_nxt;
      r_cols     <= w_cols_nxt;
      r_done     <= (w_state_nxt == ST_DONE);
      r_idle     <= (w_state_nxt == ST_IDLE);
      r_ce0      <= w_ce0_nxt;
      r_ce1      <= w_ce1_nxt;
      r_addr0    <= w_addr0_nxt;
      r_addr1    <= w_addr1_nxt;
    end
  end

  // Write data is formed from the target word arriving on the read port this cycle
  assign w_prod = r_req.k * r_piv_word;
  assign M_e_d1 = M_e_q0 - w_prod;

  assign ap_done      = r_done;
  assign ap_ready     = r_done;
  assign ap_idle      = r_idle;
  assign M_e_address0 = r_addr0;
  assign M_e_ce0      = r_ce0;
  assign M_e_address1 = r_addr1;
  assign M_e_ce1      = r_ce1;
  assign M_e_we1      = r_ce1;
  assign skipped      = r_skipped;
  assign err_range    = r_err;
  assign cols_written = r_cols;

endmodule
